// File: rtl/seg7_decoder.sv
// Receive-side seven-segment decoder: debounces an active-low segment bus,
// maps each stable pattern back to a hex digit and hands it out via valid/ready.
module seg7_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] seg_n,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic       overrun,
  output logic [7:0] err_count
);

  // Handshake: an event is transferred on a rising edge where out_valid && out_ready;
  // out_valid never drops without an accept, and its payload is held while stalled.

  localparam logic [7:0] SAT   = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK = 7'h7F;

  logic [6:0] seg_q;
  logic [6:0] last_pat;
  logic [7:0] cnt;
  logic       same;
  logic       fire;
  logic       blank;
  logic       match;
  logic [3:0] dec;
  logic [6:0] pat;

  always_comb begin
    same  = en && (seg_n == seg_q);
    // Fire only on the edge where the count reaches SAT, so a held pattern reports once.
    fire  = same && (cnt == SAT - 8'd1) && (seg_q != last_pat);
    blank = (seg_q == BLANK);
    pat   = ~seg_q;
    match = 1'b1;
    dec   = 4'h0;
    case (pat)
      7'h3F: dec = 4'h0;
      7'h06: dec = 4'h1;
      7'h5B: dec = 4'h2;
      7'h4F: dec = 4'h3;
      7'h66: dec = 4'h4;
      7'h6D: dec = 4'h5;
      7'h7D: dec = 4'h6;
      7'h07: dec = 4'h7;
      7'h7F: dec = 4'h8;
      7'h6F: dec = 4'h9;
      7'h77: dec = 4'hA;
      7'h7C: dec = 4'hB;
      7'h39: dec = 4'hC;
      7'h5E: dec = 4'hD;
      7'h79: dec = 4'hE;
      7'h71: dec = 4'hF;
      default: match = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q     <= BLANK;
      last_pat  <= BLANK;
      cnt       <= 8'd0;
      out_valid <= 1'b0;
      out_digit <= 4'h0;
      out_err   <= 1'b0;
      overrun   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      seg_q <= seg_n;
      if (!same)
        cnt <= 8'd0;
      else if (cnt != SAT)
        cnt <= cnt + 8'd1;

      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (fire) begin
        last_pat <= seg_q;
        if (!blank) begin
          // Invalid patterns are counted even when the event itself is dropped.
          if (!match && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
          if (!out_valid || out_ready) begin
            out_valid <= 1'b1;
            out_digit <= match ? dec : 4'h0;
            out_err   <= !match;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder: reset, latency, sweep, glitch, blank, error,
// stall/overrun, reset-while-pending and enable gating.
module tb_seg7_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [6:0] seg_n;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_err;
  logic       overrun;
  logic [7:0] err_count;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seg_n(seg_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_err(out_err), .overrun(overrun), .err_count(err_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every accepted event must match the front of exp_q ({err,digit}).
  always @(posedge clk) begin
    logic [4:0] obs;
    logic [4:0] exp_v;
    if (rst_n && out_valid && out_ready) begin
      obs   = {out_err, out_digit};
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1F;
      n_vec++;
      assert (obs === exp_v) else begin
        n_err++;
        $error("FAIL accept observed=%0h expected=%0h", obs, exp_v);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; seg_n = 7'h7F; out_ready = 1'b1;
    tick(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_digit", out_digit, 0);
    chk("rst_err", out_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_errcnt", err_count, 0);
    rst_n = 1'b1;

    // Latency: digit 2 seen after the 5th edge, one-cycle pulse
    seg_n = ~7'h5B;
    exp_q.push_back(5'h02);
    tick(4);
    chk("lat_early", out_valid, 0);
    tick(1);
    chk("lat_valid", out_valid, 1);
    chk("lat_digit", out_digit, 2);
    chk("lat_err", out_err, 0);
    tick(1);
    chk("lat_pulse", out_valid, 0);
    tick(4);
    chk("lat_once", out_valid, 0);

    // Sweep all digits
    for (int d = 0; d < 16; d++) begin
      seg_n = ~tab[d];
      exp_q.push_back({1'b0, 4'(d)});
      tick(6);
    end
    chk("sweep_errcnt", err_count, 0);
    chk("sweep_idle", out_valid, 0);

    // Short glitch of digit 1 then digit 3
    seg_n = ~7'h06;
    tick(3);
    seg_n = ~7'h4F;
    exp_q.push_back(5'h03);
    tick(6);

    // Digit 1, blank, digit 1 again, then an invalid pattern
    seg_n = ~7'h06;
    exp_q.push_back(5'h01);
    tick(6);
    seg_n = 7'h7F;
    tick(6);
    chk("blank_idle", out_valid, 0);
    seg_n = ~7'h06;
    exp_q.push_back(5'h01);
    tick(6);
    seg_n = ~7'h01;
    exp_q.push_back(5'h10);
    tick(5);
    chk("inv_valid", out_valid, 1);
    chk("inv_err", out_err, 1);
    chk("inv_digit", out_digit, 0);
    chk("inv_errcnt", err_count, 1);
    tick(1);

    // Stall: digit 5 held, digit 7 dropped
    out_ready = 1'b0;
    seg_n = ~7'h6D;
    exp_q.push_back(5'h05);
    tick(6);
    seg_n = ~7'h07;
    tick(6);
    chk("stall_valid", out_valid, 1);
    chk("stall_digit", out_digit, 5);
    chk("stall_overrun", overrun, 1);
    out_ready = 1'b1;
    tick(1);
    chk("drain_valid", out_valid, 0);
    tick(2);
    chk("drain_idle", out_valid, 0);
    chk("overrun_sticky", overrun, 1);

    // Reset while digit 9 pending, then reported again
    out_ready = 1'b0;
    seg_n = ~7'h6F;
    tick(6);
    chk("pend_valid", out_valid, 1);
    chk("pend_digit", out_digit, 9);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_digit", out_digit, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_errcnt", err_count, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(5'h09);
    tick(4);
    chk("rerep_early", out_valid, 0);
    tick(1);
    chk("rerep_valid", out_valid, 1);
    chk("rerep_digit", out_digit, 9);
    tick(1);

    // Enable gating: no event while en=0, counter restarts on enable
    en = 1'b0;
    seg_n = ~7'h66;
    tick(8);
    chk("en_off", out_valid, 0);
    en = 1'b1;
    exp_q.push_back(5'h04);
    tick(3);
    chk("en_early", out_valid, 0);
    tick(1);
    chk("en_valid", out_valid, 1);
    chk("en_digit", out_digit, 4);
    tick(2);

    chk("events_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
